// File: rtl/pipe_dff_chain.sv
// Stallable WIDTH x DEPTH register pipeline with a matching valid bit and a registered occupancy count.
// Define DFF_CHAIN_TAP_EN to add the tap_sel/tap_q/tap_valid combinational stage read port.
module pipe_dff_chain #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned OCC_W = $clog2(DEPTH + 1),
  localparam int unsigned TAP_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
`ifdef DFF_CHAIN_TAP_EN
  input  logic [TAP_W-1:0] tap_sel,
  output logic [WIDTH-1:0] tap_q,
  output logic             tap_valid,
`endif
  output logic [OCC_W-1:0] occ
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  always_comb begin
    stage_d = stage_q;
    vld_d   = vld_q;
    occ_d   = occ_q;
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_d[i] = '0;
      end
      vld_d = '0;
      occ_d = '0;
    end else if (en) begin
      stage_d[0] = d;
      vld_d[0]   = d_valid;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
        vld_d[i]   = vld_q[i-1];
      end
      // occ never exceeds DEPTH, so the wrap-free OCC_W arithmetic is exact
      occ_d = occ_q + OCC_W'(d_valid) - OCC_W'(vld_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
      vld_q <= '0;
      occ_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
      vld_q <= vld_d;
      occ_q <= occ_d;
    end
  end

  assign q       = stage_q[DEPTH-1];
  assign q_valid = vld_q[DEPTH-1];
  assign occ     = occ_q;

`ifdef DFF_CHAIN_TAP_EN
  // Compare-and-select keeps out-of-range selects at zero for any DEPTH.
  always_comb begin
    tap_q     = '0;
    tap_valid = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (tap_sel == TAP_W'(i)) begin
        tap_q     = stage_q[i];
        tap_valid = vld_q[i];
      end
    end
  end
`endif

endmodule
